// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and defaults for the UART transmit scheduler.
//   sched_state_t : scheduler FSM states
//   DATA_W_DEF    : default character width
//   START_TO_DEF  : default cycles allowed for tdre to fall after a start strobe
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        GRANT     = 3'd1,
        START     = 3'd2,
        WAIT_BUSY = 3'd3,
        WAIT_DONE = 3'd4
    } sched_state_t;

    localparam int DATA_W_DEF   = 8;
    localparam int START_TO_DEF = 16;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick. The search starts one past the last served
// requester and wraps modulo NREQ, so the last winner has lowest priority.
// Ports:
//   req    : request vector
//   last   : index of the last served requester (held by the caller)
//   valid  : at least one request present
//   winner : index of the selected requester (meaningful when valid)
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last,
    output logic             valid,
    output logic [IDX_W-1:0] winner
);

    logic [IDX_W-1:0] idx_s;

    // Scan offsets 1..NREQ from the last winner; first hit wins.
    always_comb begin
        valid  = 1'b0;
        winner = last;
        idx_s  = last;
        for (int k = 1; k <= NREQ; k++) begin
            idx_s = IDX_W'((int'(last) + k) % NREQ);
            if (!valid && req[idx_s]) begin
                valid  = 1'b1;
                winner = idx_s;
            end else begin
                valid  = valid;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler
// Shares one UART transmitter among NREQ requesters with round-robin
// arbitration. A grant captures the winner's byte onto tx_data, a one-cycle
// ready strobe starts the UART, and the UART's tdre flag is tracked through its
// busy (low) and empty (high) phases before a per-requester done pulse.
// Ports:
//   clk, clr_n    : clock (rising edge), asynchronous active-low reset
//   req, req_data : per-requester level request and byte (slot i at i*DATA_W)
//   gnt, done     : one-hot single-cycle grant / completion pulses
//   tx_data,ready : byte and start strobe to the UART
//   tdre          : UART transmit register empty (1 = idle)
//   busy, owner   : scheduler not idle; current or last granted requester
//   tx_count      : completed transmissions (wraps)
//   timeout_err   : sticky, tdre failed to fall within START_TO cycles
//   err_clr       : synchronous clear of timeout_err (a new timeout wins)
// -----------------------------------------------------------------------------
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int START_TO = START_TO_DEF,
    parameter int CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     clr_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          done,
    output logic [DATA_W-1:0]        tx_data,
    output logic                     ready,
    input  logic                     tdre,
    output logic                     busy,
    output logic [$clog2(NREQ)-1:0]  owner,
    output logic [CNT_W-1:0]         tx_count,
    output logic                     timeout_err,
    input  logic                     err_clr
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int TO_W  = $clog2(START_TO + 1);
    localparam logic [NREQ-1:0] ONE_S = NREQ'(1'b1);

    sched_state_t       state_q, state_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic [NREQ-1:0]    done_q, done_d;
    logic [DATA_W-1:0]  tx_data_q, tx_data_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]   tx_count_q, tx_count_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic               err_q, err_d;

    logic               arb_valid_s;
    logic [IDX_W-1:0]   arb_win_s;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req    (req),
        .last   (last_q),
        .valid  (arb_valid_s),
        .winner (arb_win_s)
    );

    // Next-state and next-output logic for the scheduler FSM.
    always_comb begin
        state_d    = state_q;
        gnt_d      = '0;
        done_d     = '0;
        ready_d    = 1'b0;
        tx_data_d  = tx_data_q;
        owner_d    = owner_q;
        last_d     = last_q;
        tx_count_d = tx_count_q;
        to_cnt_d   = to_cnt_q;
        if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end

        case (state_q)
            IDLE: begin
                // Grant only while the UART is empty; byte, owner and pointer
                // are latched here so they are already valid in the gnt cycle.
                if (arb_valid_s && tdre) begin
                    state_d   = GRANT;
                    gnt_d     = ONE_S << arb_win_s;
                    tx_data_d = req_data[int'(arb_win_s)*DATA_W +: DATA_W];
                    owner_d   = arb_win_s;
                    last_d    = arb_win_s;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                ready_d = 1'b1;
                state_d = START;
            end
            START: begin
                to_cnt_d = '0;
                state_d  = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!tdre) begin
                    state_d = WAIT_DONE;
                end else if ((to_cnt_q + TO_W'(1'b1)) == TO_W'(START_TO)) begin
                    // Timeout set overrides a same-cycle err_clr.
                    to_cnt_d = to_cnt_q + TO_W'(1'b1);
                    err_d    = 1'b1;
                    state_d  = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1'b1);
                end
            end
            WAIT_DONE: begin
                if (tdre) begin
                    done_d     = ONE_S << owner_q;
                    tx_count_d = tx_count_q + CNT_W'(1'b1);
                    state_d    = IDLE;
                end else begin
                    state_d = WAIT_DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // Scheduler state and registered outputs.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            done_q     <= '0;
            tx_data_q  <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            owner_q    <= '0;
            last_q     <= IDX_W'(NREQ - 1);
            tx_count_q <= '0;
            to_cnt_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            tx_data_q  <= tx_data_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            tx_count_q <= tx_count_d;
            to_cnt_q   <= to_cnt_d;
            err_q      <= err_d;
        end
    end

    assign gnt         = gnt_q;
    assign done        = done_q;
    assign tx_data     = tx_data_q;
    assign ready       = ready_q;
    assign busy        = busy_q;
    assign owner       = owner_q;
    assign tx_count    = tx_count_q;
    assign timeout_err = err_q;

endmodule
